// File: rtl/player_motion.sv
// player_motion: per-frame player kinematics covering walking, gravity, the jump FSM, wall blocking and fall-off respawn.
// Optional feature macro PLAYER_DOUBLE_JUMP_EN allows one extra jump while airborne.
module player_motion #(
  parameter logic [9:0]  SIZE           = 10'd15,
  parameter logic [13:0] SPEED          = 14'd6,
  parameter logic [13:0] MAP_LEN        = 14'd4479,
  parameter logic [9:0]  START_X        = 10'd100,
  parameter logic [9:0]  START_Y        = 10'd300,
  parameter logic [7:0]  JUMP_V         = 8'd12,
  parameter logic [7:0]  MAX_FALL       = 8'd8,
  parameter logic [9:0]  Y_MAX          = 10'd479,
  parameter logic [5:0]  RESPAWN_FRAMES = 6'd30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [13:0] top,
  input  logic [13:0] top_left,
  input  logic [13:0] top_right,
  input  logic        can_move,
  input  logic [13:0] excess,
  output logic [13:0] player_location,
  output logic [9:0]  Player_X,
  output logic [9:0]  Player_Y,
  output logic        is_move,
  output logic [13:0] excess_is_move,
  output logic        on_ground,
  output logic        dead
);

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic signed [15:0] X_MAX = 16'sd639 - $signed({6'd0, SIZE});

  typedef enum logic [1:0] {GROUND, JUMP, FALL, DEAD} state_t;

  state_t             state, state_next;
  logic               frame_clk_delayed, tick;
  logic signed [8:0]  vy, vy_next, vy_inc;
  logic [9:0]         y_next, x_next;
  logic [13:0]        loc_next, step, feet;
  logic [5:0]         dead_cnt, cnt_next;
  logic               jump_armed, armed_next, jump_start, respawn, air_jump;
  logic               key_l, key_r, key_w;
  logic signed [15:0] feet_s, vy_s, y_s, top_s, y_sum, fall_feet, x_calc;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic               dj_used, dj_next;
`endif

  assign key_l     = (keycode == KEY_A);
  assign key_r     = (keycode == KEY_D);
  assign key_w     = (keycode == KEY_W);
  assign feet      = {4'd0, Player_Y} + {4'd0, SIZE};
  assign feet_s    = $signed({2'b00, feet});
  assign vy_s      = $signed({{7{vy[8]}}, vy});
  assign y_s       = $signed({6'd0, Player_Y});
  assign top_s     = $signed({2'b00, top});
  assign y_sum     = y_s + vy_s;
  assign fall_feet = feet_s + vy_s;
  assign vy_inc    = vy + 9'sd1;
  assign on_ground = (state == GROUND);
  assign dead      = (state == DEAD);

  // Step grant: a wall beside the feet blocks fully, a map edge grants only what is left.
  always_comb begin
    is_move        = 1'b0;
    excess_is_move = '0;
    if (state != DEAD) begin
      if (key_r) begin
        if (top_right >= feet) begin
          if (player_location + SPEED > MAP_LEN) excess_is_move = MAP_LEN - player_location;
          else                                   is_move = 1'b1;
        end
      end else if (key_l) begin
        if (top_left >= feet) begin
          if (player_location < SPEED) excess_is_move = player_location;
          else                         is_move = 1'b1;
        end
      end
    end
  end

  always_comb begin
    step     = is_move ? SPEED : excess_is_move;
    loc_next = player_location;
    x_calc   = $signed({6'd0, Player_X});
    if (state != DEAD && (key_l || key_r)) begin
      loc_next = key_r ? player_location + step : player_location - step;
      if (can_move)
        x_calc = key_r ? $signed({6'd0, Player_X}) + $signed({2'b00, step})
                       : $signed({6'd0, Player_X}) - $signed({2'b00, step});
      else if (excess != 14'd0)
        x_calc = key_r ? 16'sd320 + $signed({2'b00, excess})
                       : 16'sd320 - $signed({2'b00, excess});
    end
    if (x_calc < 16'sd0)     x_next = 10'd0;
    else if (x_calc > X_MAX) x_next = X_MAX[9:0];
    else                     x_next = x_calc[9:0];
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  assign air_jump = (state == JUMP || state == FALL) && !dj_used && key_w && jump_armed;
`else
  assign air_jump = 1'b0;
`endif

  always_comb begin
    state_next = state;
    vy_next    = vy;
    y_next     = Player_Y;
    cnt_next   = dead_cnt;
    jump_start = 1'b0;
    respawn    = 1'b0;
    if (air_jump) begin
      vy_next    = -$signed({1'b0, JUMP_V});
      state_next = JUMP;
      jump_start = 1'b1;
    end else begin
      case (state)
        GROUND: begin
          if (key_w && jump_armed) begin
            vy_next    = -$signed({1'b0, JUMP_V});
            state_next = JUMP;
            jump_start = 1'b1;
          end else if (top > feet) begin
            vy_next    = 9'sd0;
            state_next = FALL;
          end else begin
            y_next = top[9:0] - SIZE;
          end
        end
        JUMP: begin
          if (y_sum < 16'sd0) begin
            y_next     = 10'd0;
            vy_next    = 9'sd0;
            state_next = FALL;
          end else begin
            y_next  = y_sum[9:0];
            vy_next = vy_inc;
            if (vy_inc >= 9'sd0) state_next = FALL;
          end
        end
        FALL: begin
          // Landing is tested before gravity so a fast fall cannot tunnel through the floor.
          if (feet_s <= top_s && fall_feet >= top_s) begin
            y_next     = top[9:0] - SIZE;
            vy_next    = 9'sd0;
            state_next = GROUND;
          end else begin
            y_next  = y_sum[9:0];
            vy_next = (vy_inc > $signed({1'b0, MAX_FALL})) ? $signed({1'b0, MAX_FALL}) : vy_inc;
            if (fall_feet > $signed({6'd0, Y_MAX})) begin
              state_next = DEAD;
              cnt_next   = 6'd0;
            end
          end
        end
        default: begin
          if (dead_cnt == RESPAWN_FRAMES - 6'd1) begin
            respawn    = 1'b1;
            state_next = GROUND;
            vy_next    = 9'sd0;
            y_next     = START_Y - SIZE;
            cnt_next   = 6'd0;
          end else begin
            cnt_next = dead_cnt + 6'd1;
          end
        end
      endcase
    end
    if (jump_start)  armed_next = 1'b0;
    else if (!key_w) armed_next = 1'b1;
    else             armed_next = jump_armed;
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  always_comb begin
    dj_next = dj_used;
    if (air_jump)                                    dj_next = 1'b1;
    else if (state_next == GROUND && state != GROUND) dj_next = 1'b0;
  end
`endif

  // Platform outputs are only valid in the tick cycle, so every update is qualified by tick.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_clk_delayed <= 1'b0;
      tick              <= 1'b0;
      state             <= GROUND;
      vy                <= 9'sd0;
      player_location   <= {4'd0, START_X};
      Player_X          <= START_X;
      Player_Y          <= START_Y - SIZE;
      dead_cnt          <= 6'd0;
      jump_armed        <= 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_used           <= 1'b0;
`endif
    end else begin
      frame_clk_delayed <= frame_clk;
      tick              <= frame_clk & ~frame_clk_delayed;
      if (tick) begin
        state      <= state_next;
        vy         <= vy_next;
        Player_Y   <= y_next;
        dead_cnt   <= cnt_next;
        jump_armed <= respawn ? 1'b1 : armed_next;
`ifdef PLAYER_DOUBLE_JUMP_EN
        dj_used    <= dj_next;
`endif
        if (respawn) begin
          player_location <= {4'd0, START_X};
          Player_X        <= START_X;
        end else begin
          player_location <= loc_next;
          Player_X        <= x_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed scenarios plus random play, checked against a frame-level reference model.
module tb_player_motion;

  localparam int SPEED = 6, SIZE = 15, MAP_LEN = 4479, START_X = 100, START_Y = 300;
  localparam int JUMP_V = 12, MAX_FALL = 8, Y_MAX = 479, RESPAWN = 30;
  localparam logic [7:0] K_A = 8'h04, K_D = 8'h07, K_W = 8'h1A;
  localparam int ST_GROUND = 0, ST_JUMP = 1, ST_FALL = 2, ST_DEAD = 3;
`ifdef PLAYER_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  // clock / reset
  logic        Clk, Reset, frame_clk, cm;
  logic [7:0]  kc;
  logic [13:0] t, tl, tr, ex;
  logic [13:0] player_location, excess_is_move;
  logic [9:0]  Player_X, Player_Y;
  logic        is_move, on_ground, dead;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  player_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(kc),
    .top(t), .top_left(tl), .top_right(tr), .can_move(cm), .excess(ex),
    .player_location(player_location), .Player_X(Player_X), .Player_Y(Player_Y),
    .is_move(is_move), .excess_is_move(excess_is_move), .on_ground(on_ground), .dead(dead)
  );

  int n_assert, n_fail;
  int m_loc, m_x, m_y, m_vy, m_st, m_cnt;
  bit m_armed, m_dj;
  int e_move, e_exc;
  logic [13:0] exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loc = START_X; m_x = START_X; m_y = START_Y - SIZE; m_vy = 0;
    m_st = ST_GROUND; m_cnt = 0; m_armed = 1; m_dj = 0;
  endtask

  task automatic model_move();
    int feet;
    feet = m_y + SIZE;
    e_move = 0; e_exc = 0;
    if (m_st != ST_DEAD) begin
      if (kc == K_D) begin
        if (!(int'(tr) < feet)) begin
          if (m_loc + SPEED > MAP_LEN) e_exc = MAP_LEN - m_loc;
          else e_move = 1;
        end
      end else if (kc == K_A) begin
        if (!(int'(tl) < feet)) begin
          if (m_loc < SPEED) e_exc = m_loc;
          else e_move = 1;
        end
      end
    end
  endtask

  task automatic model_tick();
    int step, feet, dir, ti, nloc, nx, ny, nvy, nst, ncnt;
    bit ndj, narm, started, resp;
    ti = int'(t);
    step = (e_move != 0) ? SPEED : e_exc;
    feet = m_y + SIZE;
    nloc = m_loc; nx = m_x; ny = m_y; nvy = m_vy; nst = m_st; ncnt = m_cnt;
    ndj = m_dj; started = 0; resp = 0;
    if (m_st != ST_DEAD && (kc == K_A || kc == K_D)) begin
      dir = (kc == K_D) ? 1 : -1;
      nloc = m_loc + dir * step;
      if (cm) nx = m_x + dir * step;
      else if (ex != 0) nx = 320 + dir * int'(ex);
      if (nx < 0) nx = 0;
      if (nx > 639 - SIZE) nx = 639 - SIZE;
    end
    if (DJ && (m_st == ST_JUMP || m_st == ST_FALL) && !m_dj && kc == K_W && m_armed) begin
      nvy = -JUMP_V; nst = ST_JUMP; ndj = 1; started = 1;
    end else if (m_st == ST_GROUND) begin
      if (kc == K_W && m_armed) begin nvy = -JUMP_V; nst = ST_JUMP; started = 1; end
      else if (ti > feet) begin nvy = 0; nst = ST_FALL; end
      else ny = ti - SIZE;
    end else if (m_st == ST_JUMP) begin
      if (m_y + m_vy < 0) begin ny = 0; nvy = 0; nst = ST_FALL; end
      else begin
        ny = m_y + m_vy; nvy = m_vy + 1;
        if (nvy >= 0) nst = ST_FALL;
      end
    end else if (m_st == ST_FALL) begin
      if (feet <= ti && feet + m_vy >= ti) begin
        ny = ti - SIZE; nvy = 0; nst = ST_GROUND; ndj = 0;
      end else begin
        ny = m_y + m_vy;
        nvy = (m_vy + 1 > MAX_FALL) ? MAX_FALL : m_vy + 1;
        if (feet + m_vy > Y_MAX) begin nst = ST_DEAD; ncnt = 0; end
      end
    end else begin
      if (m_cnt == RESPAWN - 1) resp = 1;
      else ncnt = m_cnt + 1;
    end
    narm = started ? 1'b0 : (kc != K_W) ? 1'b1 : m_armed;
    m_loc = nloc; m_x = nx; m_y = ny; m_vy = nvy; m_st = nst; m_cnt = ncnt;
    m_dj = ndj; m_armed = narm;
    if (resp) model_reset();
  endtask

  // driver: one frame_clk pulse, sampled on the falling clock edge afterwards
  task automatic pulse();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk) frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic step_check(input string tag);
    #1;
    model_move();
    chk({tag, " is_move"}, int'(is_move), e_move);
    chk({tag, " excess_is_move"}, int'(excess_is_move), e_exc);
    pulse();
    model_tick();
    exp_q.push_back(14'(m_loc));
    chk({tag, " loc"}, int'(player_location), int'(exp_q.pop_front()));
    chk({tag, " X"}, int'(Player_X), m_x);
    chk({tag, " Y"}, int'(Player_Y), m_y);
    chk({tag, " on_ground"}, int'(on_ground), int'(m_st == ST_GROUND));
    chk({tag, " dead"}, int'(dead), int'(m_st == ST_DEAD));
  endtask

  task automatic do_reset();
    Reset = 1'b0; frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    model_reset();
  endtask

  task automatic set_tops(input int v);
    t = 14'(v); tl = 14'(v); tr = 14'(v);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, guard;
    n_assert = 0; n_fail = 0;
    kc = 8'h00; cm = 1'b1; ex = 14'd0; set_tops(300);
    do_reset();

    // reset state and idle frames
    #1;
    chk("reset loc", int'(player_location), 100);
    chk("reset X", int'(Player_X), 100);
    chk("reset Y", int'(Player_Y), 285);
    chk("reset on_ground", int'(on_ground), 1);
    chk("reset dead", int'(dead), 0);
    chk("reset is_move", int'(is_move), 0);
    for (int i = 0; i < 5; i++) step_check("idle");
    chk("idle loc", int'(player_location), 100);
    chk("idle Y", int'(Player_Y), 285);

    // walk right
    kc = K_D;
    for (int i = 0; i < 10; i++) step_check("walk");
    chk("walk loc", int'(player_location), 160);
    chk("walk X", int'(Player_X), 160);

    // wall on the right
    tr = 14'd280;
    for (int i = 0; i < 3; i++) step_check("wall");
    chk("wall loc", int'(player_location), 160);
    chk("wall X", int'(Player_X), 160);

    // single jump, apex and landing
    set_tops(300); kc = K_W;
    step_check("jump start");
    kc = 8'h00;
    for (int i = 0; i < 12; i++) step_check("jump rise");
    chk("jump apex Y", int'(Player_Y), 207);
    guard = 0;
    while (m_st != ST_GROUND && guard < 40) begin step_check("jump fall"); guard++; end
    chk("land on_ground", int'(on_ground), 1);
    chk("land Y", int'(Player_Y), 285);

    // fall off the map and respawn
    set_tops(600);
    guard = 0;
    while (m_st != ST_DEAD && guard < 60) begin step_check("falloff"); guard++; end
    chk("falloff dead", int'(dead), 1);
    for (int i = 0; i < RESPAWN; i++) step_check("respawn");
    chk("respawn loc", int'(player_location), 100);
    chk("respawn X", int'(Player_X), 100);
    chk("respawn Y", int'(Player_Y), 285);
    chk("respawn on_ground", int'(on_ground), 1);
    set_tops(300);

    // random play
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) begin
        r = $urandom_range(0, 9);
        t = (r < 6) ? 14'd300 : (r == 6) ? 14'd320 : (r == 7) ? 14'd60 : (r == 8) ? 14'd250 : 14'd600;
        tl = ($urandom_range(0, 3) == 0) ? 14'd200 : t;
        tr = ($urandom_range(0, 3) == 0) ? 14'd200 : t;
        cm = 1'($urandom_range(0, 1));
        ex = ($urandom_range(0, 1) == 0) ? 14'd0 : 14'($urandom_range(0, 400));
      end
      r = $urandom_range(0, 4);
      kc = (r == 0) ? 8'h00 : (r == 1) ? K_A : (r == 2) ? K_D : (r == 3) ? K_W : 8'h05;
      step_check("rand");
    end

    // map edges: right limit, then back down to a partial left step
    kc = 8'h00; cm = 1'b0; ex = 14'd0; set_tops(300);
    do_reset();
    kc = K_D; guard = 0;
    while (m_loc != MAP_LEN && guard < 800) begin step_check("right edge"); guard++; end
    chk("right edge loc", int'(player_location), MAP_LEN);
    kc = K_A; guard = 0;
    while (m_loc != 3 && guard < 800) begin step_check("left run"); guard++; end
    #1;
    chk("left edge is_move", int'(is_move), 0);
    chk("left edge excess", int'(excess_is_move), 3);
    step_check("left edge");
    chk("left edge loc", int'(player_location), 0);

    // repeated W presses in the air
    kc = K_W; step_check("dj w1");
    kc = 8'h00; for (int i = 0; i < 3; i++) step_check("dj gap1");
    kc = K_W; step_check("dj w2");
    kc = 8'h00; for (int i = 0; i < 2; i++) step_check("dj gap2");
    kc = K_W; step_check("dj w3");
    kc = 8'h00; guard = 0;
    while (m_st != ST_GROUND && guard < 80) begin step_check("dj land"); guard++; end
    chk("dj on_ground", int'(on_ground), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
